local_mem_responder: RTL and testbench
======================================

# local_mem_responder

Responder end of the load/store request path: a tightly-coupled data-memory subunit that accepts the load, store and AMO requests emitted by the load/store queue and returns load/AMO results tagged with their instruction id. It holds a word-organised synchronous RAM and applies store byte-enables, load byte/halfword extraction with sign or zero extension, and single-word atomics (LR/SC and RMW AMOs). Results leave through an id-tagged response FIFO so the writeback side can apply backpressure.

## Interface
Parameters:
- `DEPTH_WORDS`, 1024: number of 32-bit RAM words; power of two.
- `ID_W`, 3: instruction id width, equal to `$clog2(MAX_IDS)`.
- `RESP_DEPTH`, 3: response FIFO depth and outstanding-response credit limit.

Ports:
- `clk`  in  1: the single clock.
- `rst`  in  1: reset, asynchronous and active-low.
- `req_valid`  in  1: request present.
- `req_ready`  out  1: request accepted on the cycle where `req_valid & req_ready`.
- `req_addr`  in  32: byte address.
- `req_load` / `req_store` / `req_amo`  in  1 each: operation class, one-hot.
- `req_amo_type`  in  `amo_t`: AMO/LR/SC selector.
- `req_fn3`  in  3: load size and sign (LB/LH/LW/LBU/LHU).
- `req_be`  in  4: store byte enables, already lane-aligned.
- `req_data`  in  32: store data, AMO operand or SC data, already lane-aligned.
- `req_id`  in  `ID_W`: id that is returned with the response.
- `resp_valid`  out  1: response available.
- `resp_ready`  in  1: response consumed on the cycle where `resp_valid & resp_ready`.
- `resp_data`  out  32: formatted load data, old AMO value, or SC result.
- `resp_id`  out  `ID_W`: id of the response.
- `busy`  out  1: `state != IDLE | inflight != 0`.

## Operation
- RAM word index = `req_addr[$clog2(DEPTH_WORDS)+1:2]`. Upper bits are ignored, so addresses wrap. There is no misalignment check.
- Store: at the accept edge, each byte lane whose `req_be` bit is set is written. No response is produced and no credit is used.
- Load: the RAM read is issued at the accept edge. The next cycle, `req_addr[1:0]` and `req_fn3` select and extend the byte/half/word, and the result is pushed into the response FIFO with `req_id`.
- LR.W: behaves as a load of the word; additionally sets the reservation to {valid=1, word index}.
- SC.W: if the reservation is valid and its word index matches, the full word is written at the accept edge and the response is 0. Otherwise there is no write and the response is 1. The reservation is cleared in both cases. Response latency is the same as a load.
- Any store or AMO write to the reserved word clears the reservation.
- RMW AMOs (SWAP, ADD, XOR, AND, OR, MIN, MAX, MINU, MAXU) use FSM states `IDLE -> AMO_WR -> IDLE`:
  - accept in `IDLE`;
  - in `AMO_WR`, the old word is read from the RAM output, the new value is computed (signed and unsigned compares on 32 bits), the result is written at that edge, and the old value is pushed into the FIFO.
- `inflight` counter: incremented on accept of a load, LR, SC or AMO; decremented on response pop; both in the same cycle leaves it unchanged. Range 0..`RESP_DEPTH`.
- `req_ready = (state == IDLE) & (inflight < RESP_DEPTH)`. It is identical for all request types. No combinational path from `resp_ready`.
- Reset (asynchronous, any time):
  - clears FSM to `IDLE`, `inflight`, FIFO pointers and reservation valid;
  - discards any in-progress AMO write and any in-flight response;
  - RAM contents are not reset.
- Reset output values: `resp_valid=0`, `busy=0`, `req_ready=1`, `resp_data`/`resp_id` don't-care.

## Timing
- Load/LR/SC accepted at edge t: FIFO push at edge t+1; `resp_valid` high in cycle t+1→t+2 (latency 2 edges) if the FIFO was empty.
- AMO accepted at edge t: `req_ready=0` during cycle t..t+1; write and push at edge t+1; `resp_valid` from t+1; ready again after edge t+1.
- With `resp_ready` held high, back-to-back loads sustain 1 request/cycle (`inflight` settles at 2).
- A load accepted the cycle after a store to the same word returns the stored data (write-first ordering at the RAM edge).
- FIFO full (`inflight == RESP_DEPTH`): `req_ready=0`. Stores are blocked as well.
- FIFO occupancy must never exceed the credit limit (assertion).

## Structure
- Shared package `local_mem_types`:
  - `lm_state_t` (`IDLE`, `AMO_WR`);
  - `lm_resp_t` {`data[31:0]`, `id`};
  - `amo_t` and the fn3 constants come from `riscv_types`.
- Sub-module `lm_resp_fifo`: a `RESP_DEPTH`-entry `lm_resp_t` FIFO with asynchronous active-low reset, first-word-fall-through.
- The load formatter and the AMO ALU are combinational functions in the top module.

## Test plan
- SW `0xDEADBEEF` @`0x10`, then LB @`0x13`, id 5 -> `resp_data=0xFFFFFFDE`, `resp_id=5`, 2 edges after accept.
- SB with `be=0010`, data `0x0000AA00` @`0x20` (word previously `0x11223344`), then LW -> `0x1122AA44`.
- `resp_ready=0`, issue 4 loads -> 3 accepted, `req_ready=0`. Then one pop -> 4th accepted; responses in order with matching ids.
- AMOADD of `5` to word `0xFFFFFFFE` -> response `0xFFFFFFFE`, next LW `0x00000003`. `req_ready` low exactly one cycle.
- LR @`0x40`, then SW @`0x40`, then SC @`0x40` -> SC response 1, memory keeps the SW data. LR, then SC -> response 0 and the write occurs.
- Assert `rst` low during AMO_WR with 2 responses queued -> `resp_valid=0`, `busy=0`, `req_ready=1` immediately; no AMO write.

Source files
------------

// File: rtl/local_mem_responder_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// riscv_types / local_mem_types : AMO selector, load fn3 codes, responder types
// Rev 1.0
// ---------------------------------------------------------------------------
package riscv_types;
  typedef enum logic [3:0] {
    AMO_LR   = 4'd0,
    AMO_SC   = 4'd1,
    AMO_SWAP = 4'd2,
    AMO_ADD  = 4'd3,
    AMO_XOR  = 4'd4,
    AMO_AND  = 4'd5,
    AMO_OR   = 4'd6,
    AMO_MIN  = 4'd7,
    AMO_MAX  = 4'd8,
    AMO_MINU = 4'd9,
    AMO_MAXU = 4'd10
  } amo_t;

  localparam logic [2:0] FN3_LB  = 3'b000;
  localparam logic [2:0] FN3_LH  = 3'b001;
  localparam logic [2:0] FN3_LW  = 3'b010;
  localparam logic [2:0] FN3_LBU = 3'b100;
  localparam logic [2:0] FN3_LHU = 3'b101;
endpackage

package local_mem_types;
  // Response ids are carried at a fixed maximum width; the top narrows to ID_W.
  localparam int LM_ID_W_MAX = 8;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    AMO_WR = 1'b1
  } lm_state_t;

  typedef struct packed {
    logic [31:0]            data;
    logic [LM_ID_W_MAX-1:0] id;
  } lm_resp_t;
endpackage
`default_nettype wire

// File: rtl/local_mem_responder_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// local_mem_if : load/store request channel and id-tagged response channel
// Rev 1.0
// ---------------------------------------------------------------------------
interface local_mem_if #(
  parameter int ID_W = 3
) ();
  logic                   req_valid;
  logic                   req_ready;
  logic [31:0]            req_addr;
  logic                   req_load;
  logic                   req_store;
  logic                   req_amo;
  riscv_types::amo_t      req_amo_type;
  logic [2:0]             req_fn3;
  logic [3:0]             req_be;
  logic [31:0]            req_data;
  logic [ID_W-1:0]        req_id;
  logic                   resp_valid;
  logic                   resp_ready;
  logic [31:0]            resp_data;
  logic [ID_W-1:0]        resp_id;

  modport slave (
    input  req_valid, req_addr, req_load, req_store, req_amo, req_amo_type,
           req_fn3, req_be, req_data, req_id, resp_ready,
    output req_ready, resp_valid, resp_data, resp_id
  );

  modport master (
    output req_valid, req_addr, req_load, req_store, req_amo, req_amo_type,
           req_fn3, req_be, req_data, req_id, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_id
  );
endinterface
`default_nettype wire

// File: rtl/local_mem_responder_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// lm_resp_fifo : first-word-fall-through response FIFO, async active-low reset
// Rev 1.0
// ---------------------------------------------------------------------------
module lm_resp_fifo
  import local_mem_types::*;
#(
  parameter  int DEPTH = 3,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  wire logic       clk,
  input  wire logic       rst,
  input  wire logic       i_push,
  input  lm_resp_t        i_data,
  input  wire logic       i_pop,
  output logic            o_valid,
  output lm_resp_t        o_data,
  output logic [CNT_W-1:0] o_count
);
  logic [PTR_W-1:0] r_wr;
  logic [PTR_W-1:0] r_rd;
  logic [CNT_W-1:0] r_cnt;
  lm_resp_t         r_mem [DEPTH];
  logic             w_pop;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_pop   = i_pop & (r_cnt != '0);
  assign o_valid = (r_cnt != '0);
  assign o_data  = r_mem[r_rd];
  assign o_count = r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (i_push) r_wr <= ptr_next(r_wr);
      if (w_pop)  r_rd <= ptr_next(r_rd);
      r_cnt <= r_cnt + CNT_W'(i_push) - CNT_W'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr] <= i_data;
  end
endmodule
`default_nettype wire

// File: rtl/local_mem_responder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// local_mem_responder : tightly-coupled data RAM serving loads, stores, LR/SC
// and RMW AMOs, returning id-tagged results through a credit-limited FIFO.
// Rev 1.0
// ---------------------------------------------------------------------------
module local_mem_responder
  import local_mem_types::*;
  import riscv_types::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int ID_W        = 3,
  parameter int RESP_DEPTH  = 3
) (
  input  wire logic  clk,
  input  wire logic  rst,
  local_mem_if.slave bus,
  output logic       busy
);
  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int CNT_W = $clog2(RESP_DEPTH + 1);

  lm_state_t        r_state;
  lm_state_t        w_state_nxt;
  logic [CNT_W-1:0] r_inflight;
  logic [31:0]      r_mem [DEPTH_WORDS];
  logic [31:0]      r_rdata;
  logic             r_pend_valid;
  logic             r_pend_sc;
  logic             r_pend_sc_fail;
  logic [2:0]       r_pend_fn3;
  logic [1:0]       r_pend_off;
  logic [ID_W-1:0]  r_pend_id;
  amo_t             r_amo_type;
  logic [31:0]      r_amo_opnd;
  logic [IDX_W-1:0] r_amo_idx;
  logic             r_res_valid;
  logic [IDX_W-1:0] r_res_idx;

  logic             w_accept, w_is_lr, w_is_sc, w_is_rmw, w_sc_ok;
  logic             w_credit, w_push, w_pop, w_fifo_valid, w_unused;
  logic [IDX_W-1:0] w_idx, w_widx;
  logic [3:0]       w_we;
  logic [31:0]      w_wdata, w_amo_new;
  lm_resp_t         w_push_data, w_head;
  logic [CNT_W-1:0] w_fifo_cnt;

  function automatic logic [31:0] fmt_load(input logic [31:0] w, input logic [1:0] off,
                                           input logic [2:0] fn3);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(w >> {off, 3'b000});
    h = off[1] ? w[31:16] : w[15:0];
    case (fn3)
      FN3_LB:  return {{24{b[7]}}, b};
      FN3_LBU: return {24'h0, b};
      FN3_LH:  return {{16{h[15]}}, h};
      FN3_LHU: return {16'h0, h};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] amo_alu(input amo_t op, input logic [31:0] a,
                                          input logic [31:0] b);
    case (op)
      AMO_ADD:  return a + b;
      AMO_XOR:  return a ^ b;
      AMO_AND:  return a & b;
      AMO_OR:   return a | b;
      AMO_MIN:  return ($signed(a) < $signed(b)) ? a : b;
      AMO_MAX:  return ($signed(a) > $signed(b)) ? a : b;
      AMO_MINU: return (a < b) ? a : b;
      AMO_MAXU: return (a > b) ? a : b;
      default:  return b;
    endcase
  endfunction

  assign w_accept  = bus.req_valid & bus.req_ready;
  assign w_idx     = bus.req_addr[IDX_W+1:2];
  assign w_is_lr   = bus.req_amo & (bus.req_amo_type == AMO_LR);
  assign w_is_sc   = bus.req_amo & (bus.req_amo_type == AMO_SC);
  assign w_is_rmw  = bus.req_amo & ~w_is_lr & ~w_is_sc;
  assign w_sc_ok   = r_res_valid & (r_res_idx == w_idx);
  assign w_credit  = w_accept & (bus.req_load | bus.req_amo);
  assign w_pop     = bus.resp_valid & bus.resp_ready;
  assign w_amo_new = amo_alu(r_amo_type, r_rdata, r_amo_opnd);
  assign w_unused  = ^{bus.req_addr[31:IDX_W+2], w_head.id};

  // Single RAM write port: the AMO write owns it in AMO_WR, where no request can be accepted.
  always_comb begin
    w_we    = 4'b0000;
    w_widx  = w_idx;
    w_wdata = bus.req_data;
    if (r_state == AMO_WR) begin
      w_we    = 4'hF;
      w_widx  = r_amo_idx;
      w_wdata = w_amo_new;
    end else if (w_accept & bus.req_store) begin
      w_we = bus.req_be;
    end else if (w_accept & w_is_sc & w_sc_ok) begin
      w_we = 4'hF;
    end
  end

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (w_we[b] & rst) r_mem[w_widx][8*b +: 8] <= w_wdata[8*b +: 8];
    end
    if (w_accept & (bus.req_load | w_is_lr | w_is_rmw)) r_rdata <= r_mem[w_idx];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept & w_is_rmw) w_state_nxt = AMO_WR;
      AMO_WR:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready = (r_state == IDLE) && (r_inflight < CNT_W'(RESP_DEPTH));
    busy          = (r_state != IDLE) || (r_inflight != '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pend_valid   <= 1'b0;
      r_pend_sc      <= 1'b0;
      r_pend_sc_fail <= 1'b0;
      r_pend_fn3     <= FN3_LW;
      r_pend_off     <= 2'b00;
      r_pend_id      <= '0;
      r_amo_type     <= AMO_SWAP;
      r_amo_opnd     <= '0;
      r_amo_idx      <= '0;
      r_res_valid    <= 1'b0;
      r_res_idx      <= '0;
      r_inflight     <= '0;
    end else begin
      r_pend_valid <= w_accept & (bus.req_load | w_is_lr | w_is_sc);
      if (w_accept) begin
        r_pend_sc      <= w_is_sc;
        r_pend_sc_fail <= ~w_sc_ok;
        r_pend_fn3     <= bus.req_load ? bus.req_fn3 : FN3_LW;
        r_pend_off     <= bus.req_load ? bus.req_addr[1:0] : 2'b00;
        r_pend_id      <= bus.req_id;
        r_amo_type     <= bus.req_amo_type;
        r_amo_opnd     <= bus.req_data;
        r_amo_idx      <= w_idx;
      end
      if (w_accept & w_is_lr) begin
        r_res_valid <= 1'b1;
        r_res_idx   <= w_idx;
      end else if (w_accept & w_is_sc) begin
        r_res_valid <= 1'b0;
      end else if ((w_we != 4'b0000) && (w_widx == r_res_idx)) begin
        r_res_valid <= 1'b0;
      end
      r_inflight <= r_inflight + CNT_W'(w_credit) - CNT_W'(w_pop);
    end
  end

  always_comb begin
    w_push              = r_pend_valid | (r_state == AMO_WR);
    w_push_data.id      = LM_ID_W_MAX'(r_pend_id);
    if (r_state == AMO_WR)  w_push_data.data = r_rdata;
    else if (r_pend_sc)     w_push_data.data = {31'b0, r_pend_sc_fail};
    else                    w_push_data.data = fmt_load(r_rdata, r_pend_off, r_pend_fn3);
  end

  lm_resp_fifo #(
    .DEPTH (RESP_DEPTH)
  ) u_resp_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (w_push_data),
    .i_pop   (w_pop),
    .o_valid (w_fifo_valid),
    .o_data  (w_head),
    .o_count (w_fifo_cnt)
  );

  assign bus.resp_valid = w_fifo_valid;
  assign bus.resp_data  = w_head.data;
  assign bus.resp_id    = w_head.id[ID_W-1:0];

  a_fifo_bound: assert property (@(posedge clk) disable iff (!rst)
    w_fifo_cnt <= CNT_W'(RESP_DEPTH));
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
    !(w_push && !w_pop && (w_fifo_cnt == CNT_W'(RESP_DEPTH))));
endmodule
`default_nettype wire

// File: tb/tb_local_mem_responder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_local_mem_responder : randomized and directed bench against a memory model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_local_mem_responder;
  import riscv_types::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic busy;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  local_mem_if #(.ID_W(3)) bus ();

  local_mem_responder #(
    .DEPTH_WORDS (1024),
    .ID_W        (3),
    .RESP_DEPTH  (3)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] data;
    logic [2:0]  id;
    int          avail;
  } exp_t;

  logic [31:0] mm [1024];
  exp_t        q[$];
  bit          res_v = 1'b0;
  int          res_i = 0;
  bit          amo_block = 1'b0;
  bit          last_pop, last_acc;
  logic [31:0] last_data;
  logic [2:0]  last_id;
  logic [31:0] amo_pre;
  int          amo_idx;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  function automatic logic [31:0] fmt_ref(input logic [31:0] w, input logic [1:0] off,
                                          input logic [2:0] f3);
    logic [31:0] s;
    s = w >> (8 * off);
    case (f3)
      FN3_LB:  return {{24{s[7]}}, s[7:0]};
      FN3_LBU: return {24'h0, s[7:0]};
      FN3_LH:  return {{16{s[15]}}, s[15:0]};
      FN3_LHU: return {16'h0, s[15:0]};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] amo_ref(input amo_t t, input logic [31:0] a, input logic [31:0] b);
    case (t)
      AMO_SWAP: return b;
      AMO_ADD:  return a + b;
      AMO_XOR:  return a ^ b;
      AMO_AND:  return a & b;
      AMO_OR:   return a | b;
      AMO_MIN:  return ($signed(a) < $signed(b)) ? a : b;
      AMO_MAX:  return ($signed(a) < $signed(b)) ? b : a;
      AMO_MINU: return (a < b) ? a : b;
      default:  return (a < b) ? b : a;
    endcase
  endfunction

  task automatic model_accept(input bit ld, input bit st, input amo_t at, input logic [2:0] f3,
                              input logic [3:0] be, input logic [31:0] addr,
                              input logic [31:0] data, input logic [2:0] id, output bit nb);
    int idx;
    logic [31:0] old;
    idx = int'(addr[11:2]);
    nb  = 1'b0;
    if (st) begin
      for (int b = 0; b < 4; b++) if (be[b]) mm[idx][8*b +: 8] = data[8*b +: 8];
      if (be != 4'b0 && res_v && res_i == idx) res_v = 1'b0;
    end else if (ld) begin
      q.push_back('{fmt_ref(mm[idx], addr[1:0], f3), id, cyc + 2});
    end else if (at == AMO_LR) begin
      q.push_back('{mm[idx], id, cyc + 2});
      res_v = 1'b1;
      res_i = idx;
    end else if (at == AMO_SC) begin
      if (res_v && res_i == idx) begin
        mm[idx] = data;
        q.push_back('{32'd0, id, cyc + 2});
      end else begin
        q.push_back('{32'd1, id, cyc + 2});
      end
      res_v = 1'b0;
    end else begin
      old     = mm[idx];
      amo_pre = old;
      amo_idx = idx;
      mm[idx] = amo_ref(at, old, data);
      if (res_v && res_i == idx) res_v = 1'b0;
      q.push_back('{old, id, cyc + 2});
      nb = 1'b1;
    end
  endtask

  task automatic step(input bit v, input bit ld, input bit st, input bit am, input amo_t at,
                      input logic [2:0] f3, input logic [3:0] be, input logic [31:0] addr,
                      input logic [31:0] data, input logic [2:0] id, input bit rr);
    bit exp_rdy, exp_vld, nb;
    @(negedge clk);
    exp_rdy = !amo_block && (q.size() < 3);
    exp_vld = (q.size() > 0) && (q[0].avail <= cyc);
    chk("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
    chk("busy", 32'(busy), 32'(amo_block || q.size() != 0));
    chk("resp_valid", 32'(bus.resp_valid), 32'(exp_vld));
    if (exp_vld) begin
      chk("resp_data", bus.resp_data, q[0].data);
      chk("resp_id", 32'(bus.resp_id), 32'(q[0].id));
    end
    bus.req_valid    = v;
    bus.req_load     = ld;
    bus.req_store    = st;
    bus.req_amo      = am;
    bus.req_amo_type = at;
    bus.req_fn3      = f3;
    bus.req_be       = be;
    bus.req_addr     = addr;
    bus.req_data     = data;
    bus.req_id       = id;
    bus.resp_ready   = rr;
    last_pop = exp_vld && rr;
    last_acc = v && exp_rdy;
    nb = 1'b0;
    if (last_pop) begin
      last_data = bus.resp_data;
      last_id   = bus.resp_id;
      void'(q.pop_front());
    end
    if (last_acc) model_accept(ld, st, at, f3, be, addr, data, id, nb);
    @(posedge clk);
    amo_block = nb;
  endtask

  task automatic idle(input int n, input bit rr);
    repeat (n) step(1'b0, 1'b0, 1'b0, 1'b0, AMO_LR, 3'b0, 4'b0, 32'h0, 32'h0, 3'b0, rr);
  endtask

  task automatic issue(input bit ld, input bit st, input bit am, input amo_t at, input logic [2:0] f3,
                       input logic [3:0] be, input logic [31:0] addr, input logic [31:0] data,
                       input logic [2:0] id, input bit rr);
    for (int k = 0; k < 30; k++) begin
      step(1'b1, ld, st, am, at, f3, be, addr, data, id, rr);
      if (last_acc) return;
    end
    checks++;
    errors++;
    $display("FAIL accept_timeout: request at %h never accepted", addr);
  endtask

  task automatic drain();
    for (int k = 0; k < 40 && q.size() != 0; k++) idle(1, 1'b1);
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d responses left, want 0", q.size());
    end
  endtask

  task automatic sw(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    issue(1'b0, 1'b1, 1'b0, AMO_LR, 3'b0, be, a, d, 3'b0, 1'b1);
  endtask

  task automatic ld(input logic [31:0] a, input logic [2:0] f3, input logic [2:0] id, input bit rr);
    issue(1'b1, 1'b0, 1'b0, AMO_LR, f3, 4'b0, a, 32'h0, id, rr);
  endtask

  task automatic amo(input amo_t t, input logic [31:0] a, input logic [31:0] d,
                     input logic [2:0] id, input bit rr);
    issue(1'b0, 1'b0, 1'b1, t, 3'b0, 4'b0, a, d, id, rr);
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_load = 1'b0; bus.req_store = 1'b0; bus.req_amo = 1'b0;
    bus.req_amo_type = AMO_LR; bus.req_fn3 = 3'b0; bus.req_be = 4'b0; bus.req_addr = 32'h0;
    bus.req_data = 32'h0; bus.req_id = 3'b0; bus.resp_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b1;

    // Byte load with sign extension
    sw(32'h10, 32'hDEADBEEF, 4'hF);
    ld(32'h13, FN3_LB, 3'd5, 1'b1);
    drain();
    chk("lit_lb_data", last_data, 32'hFFFFFFDE);
    chk("lit_lb_id", 32'(last_id), 32'd5);

    // Partial store merge
    sw(32'h20, 32'h11223344, 4'hF);
    sw(32'h20, 32'h0000AA00, 4'b0010);
    ld(32'h20, FN3_LW, 3'd1, 1'b1);
    drain();
    chk("lit_sb_merge", last_data, 32'h1122AA44);

    // Credit limit with a stalled consumer
    ld(32'h10, FN3_LW, 3'd1, 1'b0);
    ld(32'h20, FN3_LHU, 3'd2, 1'b0);
    ld(32'h12, FN3_LH, 3'd3, 1'b0);
    idle(1, 1'b0);
    #1 chk("lit_full_ready", 32'(bus.req_ready), 32'd0);
    ld(32'h11, FN3_LBU, 3'd4, 1'b1);
    drain();
    chk("lit_order_last_id", 32'(last_id), 32'd4);
    chk("lit_order_last_data", last_data, 32'h000000BE);

    // AMOADD wraps and blocks exactly one cycle
    sw(32'h30, 32'hFFFFFFFE, 4'hF);
    amo(AMO_ADD, 32'h30, 32'd5, 3'd2, 1'b1);
    #1 chk("lit_amo_ready_low", 32'(bus.req_ready), 32'd0);
    idle(1, 1'b1);
    #1 chk("lit_amo_ready_back", 32'(bus.req_ready), 32'd1);
    drain();
    chk("lit_amo_old", last_data, 32'hFFFFFFFE);
    ld(32'h30, FN3_LW, 3'd3, 1'b1);
    drain();
    chk("lit_amo_new", last_data, 32'h00000003);

    // LR/SC: intervening store kills the reservation, clean pair succeeds
    sw(32'h40, 32'hCAFE0001, 4'hF);
    amo(AMO_LR, 32'h40, 32'h0, 3'd1, 1'b1);
    sw(32'h40, 32'h12345678, 4'hF);
    amo(AMO_SC, 32'h40, 32'h99999999, 3'd2, 1'b1);
    drain();
    chk("lit_sc_fail", last_data, 32'd1);
    ld(32'h40, FN3_LW, 3'd3, 1'b1);
    drain();
    chk("lit_sc_fail_mem", last_data, 32'h12345678);
    amo(AMO_LR, 32'h40, 32'h0, 3'd4, 1'b1);
    amo(AMO_SC, 32'h40, 32'hA5A5A5A5, 3'd5, 1'b1);
    drain();
    chk("lit_sc_ok", last_data, 32'd0);
    ld(32'h40, FN3_LW, 3'd6, 1'b1);
    drain();
    chk("lit_sc_ok_mem", last_data, 32'hA5A5A5A5);

    // Asynchronous reset in the middle of an AMO write with responses queued
    ld(32'h10, FN3_LW, 3'd1, 1'b0);
    ld(32'h20, FN3_LW, 3'd2, 1'b0);
    amo(AMO_SWAP, 32'h30, 32'h00000077, 3'd3, 1'b0);
    #2 bus.req_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("lit_mid_rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("lit_mid_rst_busy", 32'(busy), 32'd0);
    chk("lit_mid_rst_ready", 32'(bus.req_ready), 32'd1);
    q.delete();
    amo_block = 1'b0;
    res_v = 1'b0;
    mm[amo_idx] = amo_pre;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    ld(32'h30, FN3_LW, 3'd4, 1'b1);
    drain();
    chk("lit_rst_no_amo_write", last_data, 32'h00000003);

    // Randomized traffic over 16 words, with random upper address bits
    for (int w = 0; w < 16; w++) sw(32'(w * 4), $urandom(), 4'hF);
    for (int n = 0; n < 2500; n++) begin
      logic [31:0] u, a;
      logic [3:0]  wi;
      logic [1:0]  off;
      logic [2:0]  f3;
      int          kind, fs;
      bit          v, rr;
      u    = $urandom();
      wi   = 4'($urandom_range(0, 15));
      off  = 2'($urandom_range(0, 3));
      v    = ($urandom_range(0, 99) < 70);
      rr   = ($urandom_range(0, 3) != 0);
      kind = $urandom_range(0, 9);
      fs   = $urandom_range(0, 4);
      case (fs)
        0: begin f3 = FN3_LB;  end
        1: begin f3 = FN3_LBU; end
        2: begin f3 = FN3_LH;  off[0] = 1'b0; end
        3: begin f3 = FN3_LHU; off[0] = 1'b0; end
        default: begin f3 = FN3_LW; off = 2'b00; end
      endcase
      if (kind >= 3) off = 2'b00;
      a = {u[31:12], 6'b0, wi, off};
      if (kind <= 2)
        step(v, 1'b1, 1'b0, 1'b0, AMO_LR, f3, 4'b0, a, 32'h0, 3'($urandom()), rr);
      else if (kind <= 4)
        step(v, 1'b0, 1'b1, 1'b0, AMO_LR, 3'b0, 4'($urandom_range(1, 15)), a, $urandom(), 3'b0, rr);
      else if (kind == 5)
        step(v, 1'b0, 1'b0, 1'b1, AMO_LR, 3'b0, 4'b0, a, 32'h0, 3'($urandom()), rr);
      else if (kind == 6)
        step(v, 1'b0, 1'b0, 1'b1, AMO_SC, 3'b0, 4'b0, a, $urandom(), 3'($urandom()), rr);
      else
        step(v, 1'b0, 1'b0, 1'b1, amo_t'($urandom_range(2, 10)), 3'b0, 4'b0, a, $urandom(),
             3'($urandom()), rr);
    end
    drain();
    idle(2, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
